// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: three FU completion ports, ROB age/flush inputs and the CDB broadcast.
// Handshake: a completion transfers at a posedge when x_valid & x_ready are both high; valid must not depend on ready.
interface wb_arbiter_if #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 7,
  parameter int DATA_W    = 32
);
  logic                 alu_valid, b_valid, mem_valid;
  logic                 alu_ready, b_ready, mem_ready;
  logic [ROB_IDX_W-1:0] alu_rob, b_rob, mem_rob;
  logic [PREG_W-1:0]    alu_pd, b_pd, mem_pd;
  logic [DATA_W-1:0]    alu_data, b_data, mem_data;
  logic                 alu_wr, b_wr, mem_wr;
  logic [ROB_IDX_W-1:0] rob_head;
  logic                 mispredict;
  logic [ROB_IDX_W-1:0] mispredict_tag;
  logic                 cdb_valid;
  logic [ROB_IDX_W-1:0] cdb_rob;
  logic [PREG_W-1:0]    cdb_pd;
  logic [DATA_W-1:0]    cdb_data;
  logic                 cdb_wr_en;
  logic [1:0]           cdb_src;

  modport slave (
    input  alu_valid, b_valid, mem_valid,
    input  alu_rob, b_rob, mem_rob, alu_pd, b_pd, mem_pd,
    input  alu_data, b_data, mem_data, alu_wr, b_wr, mem_wr,
    input  rob_head, mispredict, mispredict_tag,
    output alu_ready, b_ready, mem_ready,
    output cdb_valid, cdb_rob, cdb_pd, cdb_data, cdb_wr_en, cdb_src
  );

  modport master (
    output alu_valid, b_valid, mem_valid,
    output alu_rob, b_rob, mem_rob, alu_pd, b_pd, mem_pd,
    output alu_data, b_data, mem_data, alu_wr, b_wr, mem_wr,
    output rob_head, mispredict, mispredict_tag,
    input  alu_ready, b_ready, mem_ready,
    input  cdb_valid, cdb_rob, cdb_pd, cdb_data, cdb_wr_en, cdb_src
  );
endinterface

// File: rtl/wb_arbiter.sv
// CDB writeback arbiter: one holding slot per FU (ALU=0, B=1, MEM=2), one grant per cycle, flush squash.
// Define WB_ARB_AGE_PRIO_EN for oldest-first grant; default build is round-robin.
module wb_arbiter #(
  parameter int ROB_IDX_W = 5,
  parameter int PREG_W    = 7,
  parameter int DATA_W    = 32
) (
  input  logic       clk,
  input  logic       reset,
  wb_arbiter_if.slave bus,
  output logic [1:0] dbg_rr
);
  typedef logic [ROB_IDX_W-1:0] tag_t;

  function automatic tag_t age_of(input tag_t t, input tag_t head);
    age_of = t - head;
  endfunction

  function automatic logic younger(input tag_t t, input tag_t head, input tag_t br);
    younger = age_of(t, head) > age_of(br, head);
  endfunction

  logic [2:0]        in_valid, in_wr;
  tag_t              in_rob  [3];
  logic [PREG_W-1:0] in_pd   [3];
  logic [DATA_W-1:0] in_data [3];

  logic [2:0]        held_q, held_d, wr_q, wr_d;
  tag_t              rob_q  [3], rob_d  [3];
  logic [PREG_W-1:0] pd_q   [3], pd_d   [3];
  logic [DATA_W-1:0] data_q [3], data_d [3];

  logic              cdb_valid_q, cdb_valid_d, cdb_wr_en_q, cdb_wr_en_d;
  tag_t              cdb_rob_q, cdb_rob_d;
  logic [PREG_W-1:0] cdb_pd_q, cdb_pd_d;
  logic [DATA_W-1:0] cdb_data_q, cdb_data_d;
  logic [1:0]        cdb_src_q, cdb_src_d;

  logic [2:0] sq_held, sq_in, elig, grant, ready, accept;
  logic [1:0] win;
  logic       any;

  always_comb begin
    in_valid   = {bus.mem_valid, bus.b_valid, bus.alu_valid};
    in_wr      = {bus.mem_wr, bus.b_wr, bus.alu_wr};
    in_rob[0]  = bus.alu_rob;  in_rob[1]  = bus.b_rob;  in_rob[2]  = bus.mem_rob;
    in_pd[0]   = bus.alu_pd;   in_pd[1]   = bus.b_pd;   in_pd[2]   = bus.mem_pd;
    in_data[0] = bus.alu_data; in_data[1] = bus.b_data; in_data[2] = bus.mem_data;
  end

  // Squash applies to both resident entries and same-cycle arrivals; the branch's own tag is never younger.
  always_comb begin
    sq_held = '0;
    sq_in   = '0;
    for (int i = 0; i < 3; i++) begin
      sq_held[i] = bus.mispredict & younger(rob_q[i], bus.rob_head, bus.mispredict_tag);
      sq_in[i]   = bus.mispredict & younger(in_rob[i], bus.rob_head, bus.mispredict_tag);
    end
    elig = held_q & ~sq_held;
  end

`ifdef WB_ARB_AGE_PRIO_EN
  tag_t best_age;

  always_comb begin
    any      = 1'b0;
    win      = 2'd0;
    best_age = '1;
    for (int i = 0; i < 3; i++) begin
      if (elig[i] && (!any || age_of(rob_q[i], bus.rob_head) < best_age)) begin
        any      = 1'b1;
        win      = i[1:0];
        best_age = age_of(rob_q[i], bus.rob_head);
      end
    end
  end

  assign dbg_rr = 2'd0;
`else
  typedef enum logic [1:0] {RR_ALU = 2'd0, RR_B = 2'd1, RR_MEM = 2'd2} rr_state_t;
  rr_state_t  rr_q, rr_d;
  logic [2:0] idx_w;

  // Search starts at the pointer and wraps modulo 3.
  always_comb begin
    any   = 1'b0;
    win   = 2'd0;
    idx_w = '0;
    rr_d  = rr_q;
    for (int k = 0; k < 3; k++) begin
      idx_w = {1'b0, rr_q} + 3'(k);
      if (idx_w >= 3'd3) idx_w = idx_w - 3'd3;
      if (!any && elig[idx_w[1:0]]) begin
        any = 1'b1;
        win = idx_w[1:0];
      end
    end
    if (any) begin
      case (win)
        2'd0:    rr_d = RR_B;
        2'd1:    rr_d = RR_MEM;
        default: rr_d = RR_ALU;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_q <= RR_ALU;
    else       rr_q <= rr_d;
  end

  assign dbg_rr = rr_q;
`endif

  always_comb begin
    grant = '0;
    if (any) grant[win] = 1'b1;
    ready  = reset ? 3'b000 : (~held_q | grant);
    accept = in_valid & ready;
  end

  always_comb begin
    held_d = held_q;
    wr_d   = wr_q;
    rob_d  = rob_q;
    pd_d   = pd_q;
    data_d = data_q;
    for (int i = 0; i < 3; i++) begin
      if (accept[i]) begin
        held_d[i] = ~sq_in[i];
        wr_d[i]   = in_wr[i];
        rob_d[i]  = in_rob[i];
        pd_d[i]   = in_pd[i];
        data_d[i] = in_data[i];
      end else if (grant[i] || sq_held[i]) begin
        held_d[i] = 1'b0;
      end
    end
    cdb_valid_d = any;
    cdb_wr_en_d = any & wr_q[win];
    cdb_rob_d   = cdb_rob_q;
    cdb_pd_d    = cdb_pd_q;
    cdb_data_d  = cdb_data_q;
    cdb_src_d   = cdb_src_q;
    if (any) begin
      cdb_rob_d  = rob_q[win];
      cdb_pd_d   = pd_q[win];
      cdb_data_d = data_q[win];
      cdb_src_d  = win;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      held_q      <= '0;
      wr_q        <= '0;
      cdb_valid_q <= 1'b0;
      cdb_wr_en_q <= 1'b0;
      cdb_rob_q   <= '0;
      cdb_pd_q    <= '0;
      cdb_data_q  <= '0;
      cdb_src_q   <= '0;
      for (int i = 0; i < 3; i++) begin
        rob_q[i]  <= '0;
        pd_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      held_q      <= held_d;
      wr_q        <= wr_d;
      cdb_valid_q <= cdb_valid_d;
      cdb_wr_en_q <= cdb_wr_en_d;
      cdb_rob_q   <= cdb_rob_d;
      cdb_pd_q    <= cdb_pd_d;
      cdb_data_q  <= cdb_data_d;
      cdb_src_q   <= cdb_src_d;
      for (int i = 0; i < 3; i++) begin
        rob_q[i]  <= rob_d[i];
        pd_q[i]   <= pd_d[i];
        data_q[i] <= data_d[i];
      end
    end
  end

  assign bus.alu_ready = ready[0];
  assign bus.b_ready   = ready[1];
  assign bus.mem_ready = ready[2];
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_wr_en = cdb_wr_en_q;
  assign bus.cdb_rob   = cdb_rob_q;
  assign bus.cdb_pd    = cdb_pd_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.cdb_src   = cdb_src_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed bench for wb_arbiter: single op, store, flush squash, reset mid-stream, and
// three-way contention (round-robin build) or oldest-first ordering (WB_ARB_AGE_PRIO_EN build).
module tb_wb_arbiter;
  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] dbg_rr;
  int         total = 0;
  int         bad = 0;
  logic       flush_watch = 1'b0;
  logic       bad_tag_seen = 1'b0;
  logic [6:0] exp_q[$];

  wb_arbiter_if bus ();

  wb_arbiter u_dut (
    .clk    (clk),
    .reset  (reset),
    .bus    (bus),
    .dbg_rr (dbg_rr)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    if (flush_watch && bus.cdb_valid && (bus.cdb_rob == 5'd8 || bus.cdb_rob == 5'd9))
      bad_tag_seen = 1'b1;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs();
    bus.alu_valid = 0; bus.b_valid = 0; bus.mem_valid = 0;
    bus.alu_rob = 0;   bus.b_rob = 0;   bus.mem_rob = 0;
    bus.alu_pd = 0;    bus.b_pd = 0;    bus.mem_pd = 0;
    bus.alu_data = 0;  bus.b_data = 0;  bus.mem_data = 0;
    bus.alu_wr = 0;    bus.b_wr = 0;    bus.mem_wr = 0;
    bus.mispredict = 0; bus.mispredict_tag = 0;
  endtask

  task automatic chk_ready(input string tag, input logic [2:0] exp);
    chk(tag, {61'd0, bus.mem_ready, bus.b_ready, bus.alu_ready}, {61'd0, exp});
  endtask

  initial begin
    logic [2:0] r;
    logic [6:0] e;
    int at, bt, mt;
    idle_inputs();
    bus.rob_head = 0;
    reset = 1;
    #1;
    chk_ready("reset_ready", 3'b000);
    tick(); tick();
    chk("reset_cdb_valid", bus.cdb_valid, 0);
    chk("reset_cdb_fields", {bus.cdb_wr_en, bus.cdb_src, bus.cdb_rob, bus.cdb_pd, bus.cdb_data}, 0);
    chk("reset_rr", dbg_rr, 0);
    reset = 0;
    #1;
    chk_ready("post_reset_ready", 3'b111);

    // Single ALU op
    bus.alu_valid = 1; bus.alu_rob = 3; bus.alu_pd = 40; bus.alu_data = 32'hDEAD; bus.alu_wr = 1;
    tick();
    idle_inputs();
    chk("alu_slot_latency", bus.cdb_valid, 0);
    tick();
    chk("alu_cdb_valid", bus.cdb_valid, 1);
    chk("alu_cdb_rob", bus.cdb_rob, 3);
    chk("alu_cdb_pd", bus.cdb_pd, 40);
    chk("alu_cdb_data", bus.cdb_data, 32'hDEAD);
    chk("alu_cdb_wr_en", bus.cdb_wr_en, 1);
    chk("alu_cdb_src", bus.cdb_src, 0);
    tick();
    chk("alu_cdb_drop", bus.cdb_valid, 0);
    chk("alu_cdb_hold_rob", bus.cdb_rob, 3);

    // Store completion
    bus.mem_valid = 1; bus.mem_rob = 12; bus.mem_pd = 5; bus.mem_data = 32'h1; bus.mem_wr = 0;
    tick();
    idle_inputs();
    tick();
    chk("store_valid", bus.cdb_valid, 1);
    chk("store_wr_en", bus.cdb_wr_en, 0);
    chk("store_rob_src", {bus.cdb_src, bus.cdb_rob}, {2'd2, 5'd12});
    tick();

    // Flush: ALU rob 5 and MEM rob 9 held, branch tag 7
    flush_watch = 1;
    bus.alu_valid = 1; bus.alu_rob = 5; bus.alu_pd = 11; bus.alu_data = 32'h55; bus.alu_wr = 1;
    bus.mem_valid = 1; bus.mem_rob = 9; bus.mem_pd = 12; bus.mem_data = 32'h99; bus.mem_wr = 1;
    tick();
    idle_inputs();
    bus.mispredict = 1; bus.mispredict_tag = 7;
    bus.b_valid = 1; bus.b_rob = 8; bus.b_pd = 13; bus.b_data = 32'h88; bus.b_wr = 1;
    #1;
    chk_ready("flush_ready", 3'b011);
    tick();
    idle_inputs();
    chk("flush_cdb", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob}, {1'b1, 2'd0, 5'd5});
    chk_ready("flush_slots_empty", 3'b111);
    tick();
    chk("flush_no_followup", bus.cdb_valid, 0);
    tick(); tick();
    chk("flush_no_8_9", bad_tag_seen, 0);
    flush_watch = 0;

    // Reset mid-stream with all slots held and CDB valid
    bus.alu_valid = 1; bus.alu_rob = 1; bus.alu_wr = 1;
    bus.b_valid = 1;   bus.b_rob = 2;   bus.b_wr = 1;
    bus.mem_valid = 1; bus.mem_rob = 3; bus.mem_wr = 1;
    tick();
    bus.alu_valid = 0; bus.mem_valid = 0;
    bus.b_rob = 4;
    tick();
    idle_inputs();
`ifdef WB_ARB_AGE_PRIO_EN
    chk("midrst_cdb", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob}, {1'b1, 2'd0, 5'd1});
`else
    chk("midrst_cdb", {bus.cdb_valid, bus.cdb_src, bus.cdb_rob}, {1'b1, 2'd1, 5'd2});
`endif
    reset = 1;
    #1;
    chk_ready("midrst_ready_low", 3'b000);
    tick();
    chk("midrst_cdb_clear", {bus.cdb_valid, bus.cdb_wr_en, bus.cdb_src, bus.cdb_rob, bus.cdb_pd, bus.cdb_data}, 0);
    chk_ready("midrst_ready_still_low", 3'b000);
    reset = 0;
    #1;
    chk_ready("midrst_ready_back", 3'b111);

`ifdef WB_ARB_AGE_PRIO_EN
    // Oldest-first with rob_head near wrap
    bus.rob_head = 30;
    bus.alu_valid = 1; bus.alu_rob = 2;  bus.alu_wr = 1;
    bus.b_valid = 1;   bus.b_rob = 31;   bus.b_wr = 1;
    bus.mem_valid = 1; bus.mem_rob = 0;  bus.mem_wr = 1;
    tick();
    idle_inputs();
    tick();
    chk("age_first", {bus.cdb_src, bus.cdb_rob}, {2'd1, 5'd31});
    tick();
    chk("age_second", {bus.cdb_src, bus.cdb_rob}, {2'd2, 5'd0});
    tick();
    chk("age_third", {bus.cdb_src, bus.cdb_rob}, {2'd0, 5'd2});
`else
    // Three-way contention, round-robin restarts at ALU
    for (int n = 0; n < 3; n++) begin
      exp_q.push_back({2'd0, 5'(16 + n)});
      exp_q.push_back({2'd1, 5'(20 + n)});
      exp_q.push_back({2'd2, 5'(24 + n)});
    end
    at = 16; bt = 20; mt = 24;
    for (int c = 0; c < 10; c++) begin
      bus.alu_valid = 1; bus.alu_rob = 5'(at); bus.alu_pd = 7'(at); bus.alu_data = 32'(at); bus.alu_wr = 1;
      bus.b_valid = 1;   bus.b_rob = 5'(bt);   bus.b_pd = 7'(bt);   bus.b_data = 32'(bt);   bus.b_wr = 1;
      bus.mem_valid = 1; bus.mem_rob = 5'(mt); bus.mem_pd = 7'(mt); bus.mem_data = 32'(mt); bus.mem_wr = 1;
      #1;
      r = {bus.mem_ready, bus.b_ready, bus.alu_ready};
      chk_ready($sformatf("rr_ready_c%0d", c), (c == 0) ? 3'b111 : (3'b001 << ((c - 1) % 3)));
      tick();
      if (r[0]) at++;
      if (r[1]) bt++;
      if (r[2]) mt++;
      if (c >= 1) begin
        e = (exp_q.size() > 0) ? exp_q.pop_front() : 7'h7f;
        chk($sformatf("rr_cdb_c%0d", c), {bus.cdb_valid, bus.cdb_wr_en, bus.cdb_src, bus.cdb_rob},
            {1'b1, 1'b1, e});
      end
    end
    idle_inputs();
    chk("rr_all_consumed", exp_q.size(), 0);
`endif
    tick(); tick(); tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
